// File: rtl/axis_pkt_egress_if.sv
// Beat type and bus interface for axis_pkt_egress: FIFO first-word-fall-through read port
// plus the AXI-Stream master side; "master" is the egress block, "slave" its environment.
package axis_pkt_egress_pkg;
    typedef struct packed {
        logic [31:0] tdata;
        logic        tlast;
    } axis_word_t;
endpackage

interface axis_pkt_egress_if;
    import axis_pkt_egress_pkg::*;

    logic       fifo_rd_en;
    axis_word_t fifo_rd_data;
    logic       fifo_empty;
    logic       pkt_commit;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    axis_word_t m_axis_word;

    modport master (
        output fifo_rd_en, m_axis_tvalid, m_axis_word,
        input  fifo_rd_data, fifo_empty, pkt_commit, m_axis_tready
    );

    modport slave (
        input  fifo_rd_en, m_axis_tvalid, m_axis_word,
        output fifo_rd_data, fifo_empty, pkt_commit, m_axis_tready
    );
endinterface

// File: rtl/axis_pkt_egress.sv
// Store-and-forward AXIS egress: forwards a packet from the FIFO only after its commit pulse.
// Optional AXIS_EGRESS_STATS_EN adds 32-bit beat and packet counters.
module axis_pkt_egress
    import axis_pkt_egress_pkg::*;
#(
    parameter int max_pkts = 8,
    localparam int PW = $clog2(max_pkts + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    axis_pkt_egress_if.master bus,
    output logic [PW-1:0]     pending_cnt,
    output logic              err_overflow,
    output logic              err_underrun
`ifdef AXIS_EGRESS_STATS_EN
    ,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_beats
`endif
);

    typedef enum logic [1:0] {IDLE, FWD, LAST} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic       r_tvalid;
    axis_word_t r_word;
    logic [PW-1:0] r_pending;
    logic       r_errOverflow;
    logic       r_errUnderrun;

    logic w_free;
    logic w_hs;
    logic w_tlastHs;
    logic w_readOk;
    logic w_load;
    logic w_underrun;

    always_comb begin
        w_free    = !r_tvalid || bus.m_axis_tready;
        w_hs      = r_tvalid && bus.m_axis_tready;
        w_tlastHs = w_hs && r_word.tlast;
    end

    // In LAST the next packet may only be fetched in the very cycle its predecessor's tlast leaves.
    always_comb begin
        w_nextState = r_state;
        w_readOk    = 1'b0;
        w_underrun  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: w_readOk = (r_pending != '0);
            FWD: begin
                w_readOk   = 1'b1;
                w_underrun = w_free && bus.fifo_empty;
            end
            LAST: w_readOk = w_tlastHs && (r_pending > PW'(1));
            default: w_readOk = 1'b0;
        endcase
        w_load = w_free && !bus.fifo_empty && w_readOk;
        if (w_load) begin
            w_nextState = bus.fifo_rd_data.tlast ? LAST : FWD;
        end else if (r_state == LAST && w_tlastHs) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tvalid <= 1'b0;
            r_word   <= '0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_word   <= bus.fifo_rd_data;
        end else if (w_free) begin
            r_tvalid <= 1'b0;
        end
    end

    // A commit and a tlast handshake in the same cycle cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pending     <= '0;
            r_errOverflow <= 1'b0;
            r_errUnderrun <= 1'b0;
        end else begin
            if (bus.pkt_commit && !w_tlastHs) begin
                if (r_pending == PW'(max_pkts)) begin
                    r_errOverflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + PW'(1);
                end
            end else if (w_tlastHs && !bus.pkt_commit) begin
                r_pending <= r_pending - PW'(1);
            end
            if (w_underrun) begin
                r_errUnderrun <= 1'b1;
            end
        end
    end

`ifdef AXIS_EGRESS_STATS_EN
    logic [31:0] r_statPkts;
    logic [31:0] r_statBeats;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_statPkts  <= '0;
            r_statBeats <= '0;
        end else begin
            if (w_hs) begin
                r_statBeats <= r_statBeats + 32'd1;
            end
            if (w_tlastHs) begin
                r_statPkts <= r_statPkts + 32'd1;
            end
        end
    end

    assign stat_pkts  = r_statPkts;
    assign stat_beats = r_statBeats;
`endif

    assign bus.fifo_rd_en    = w_load;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.m_axis_word   = r_word;
    assign pending_cnt       = r_pending;
    assign err_overflow      = r_errOverflow;
    assign err_underrun      = r_errUnderrun;

endmodule

// File: tb/tb_axis_pkt_egress.sv
// Directed bench for axis_pkt_egress: a queue models the FWFT FIFO, a vector table covers
// back-to-back packets, hand sequences cover gating, stalls, underrun, overflow and reset.
module tb_axis_pkt_egress;
    import axis_pkt_egress_pkg::*;

    localparam int PW = 4;

    typedef struct {
        logic        commit;
        logic        ready;
        logic        expRdEn;
        logic        expValid;
        logic [31:0] expData;
        logic        expLast;
        int          expPend;
    } vec_t;

    logic          aclk;
    logic          aresetn;
    logic [PW-1:0] pendingCnt;
    logic          errOverflow;
    logic          errUnderrun;
`ifdef AXIS_EGRESS_STATS_EN
    logic [31:0]   statPkts;
    logic [31:0]   statBeats;
`endif

    axis_word_t fifoQ[$];
    logic       lastRdEn;
    int         totalCnt;
    int         badCnt;
    vec_t       vecs[13];

    axis_pkt_egress_if ifc ();

    axis_pkt_egress #(.max_pkts(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .bus          (ifc.master),
        .pending_cnt  (pendingCnt),
        .err_overflow (errOverflow),
        .err_underrun (errUnderrun)
`ifdef AXIS_EGRESS_STATS_EN
        ,
        .stat_pkts    (statPkts),
        .stat_beats   (statBeats)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic updateFifo();
        ifc.fifo_empty   = (fifoQ.size() == 0);
        ifc.fifo_rd_data = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    task automatic pushWord(input logic [31:0] data, input logic last);
        axis_word_t w;
        w.tdata = data;
        w.tlast = last;
        fifoQ.push_back(w);
        updateFifo();
    endtask

    // One clock: drive inputs, note whether the DUT pops, advance, then retire the popped word.
    task automatic applyStimulus(input logic commit, input logic ready);
        ifc.pkt_commit    = commit;
        ifc.m_axis_tready = ready;
        #1;
        lastRdEn = ifc.fifo_rd_en;
        @(posedge aclk);
        #1;
        if (lastRdEn && fifoQ.size() > 0) void'(fifoQ.pop_front());
        updateFifo();
        ifc.pkt_commit = 1'b0;
    endtask

    task automatic doReset();
        ifc.pkt_commit    = 1'b0;
        ifc.m_axis_tready = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        checkOutput("rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        checkOutput("rst_word", {ifc.m_axis_word.tdata[30:0], ifc.m_axis_word.tlast}, 32'd0);
        checkOutput("rst_pend", 32'(pendingCnt), 32'd0);
        checkOutput("rst_errs", {30'd0, errOverflow, errUnderrun}, 32'd0);
        checkOutput("rst_rden", 32'(ifc.fifo_rd_en), 32'd0);
        aresetn = 1'b1;
    endtask

    initial begin
        int idx;
        logic r;
        axis_word_t prevWord;

        totalCnt = 0;
        badCnt   = 0;
        lastRdEn = 1'b0;
        updateFifo();

        // Packets 1..4 are preloaded for the table: 3-beat, 1-beat, 2-beat, 1-beat.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 2};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h12, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h31, 1'b1, 1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 0};

        doReset();

        // Uncommitted packet must sit in the FIFO untouched.
        for (int b = 0; b < 4; b++) pushWord(32'h60 + 32'(b), b == 3);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("nocommit_rden", 32'(lastRdEn), 32'd0);
            checkOutput("nocommit_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("commit_pend", 32'(pendingCnt), 32'd1);
        checkOutput("commit_tvalid_n", 32'(ifc.m_axis_tvalid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("p60_tvalid", 32'(ifc.m_axis_tvalid), 32'd1);
            checkOutput("p60_data", ifc.m_axis_word.tdata, 32'h60 + 32'(b));
            checkOutput("p60_last", 32'(ifc.m_axis_word.tlast), 32'(b == 3));
            checkOutput("p60_pend", 32'(pendingCnt), 32'd1);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("p60_done_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        checkOutput("p60_done_pend", 32'(pendingCnt), 32'd0);

        pushWord(32'h10, 1'b0);
        pushWord(32'h11, 1'b0);
        pushWord(32'h12, 1'b1);
        pushWord(32'h20, 1'b1);
        pushWord(32'h30, 1'b0);
        pushWord(32'h31, 1'b1);
        pushWord(32'h40, 1'b1);
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].commit, vecs[v].ready);
            checkOutput($sformatf("vec%0d_rden", v), 32'(lastRdEn), 32'(vecs[v].expRdEn));
            checkOutput($sformatf("vec%0d_tvalid", v), 32'(ifc.m_axis_tvalid), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d_pend", v), 32'(pendingCnt), 32'(vecs[v].expPend));
            if (vecs[v].expValid) begin
                checkOutput($sformatf("vec%0d_data", v), ifc.m_axis_word.tdata, vecs[v].expData);
                checkOutput($sformatf("vec%0d_last", v), 32'(ifc.m_axis_word.tlast), 32'(vecs[v].expLast));
            end
        end

        // Backpressure: ready pattern 1,0,0 repeating over a 5-beat packet.
        for (int b = 0; b < 5; b++) pushWord(32'h70 + 32'(b), b == 4);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("stall_first_rden", 32'(lastRdEn), 32'd1);
        checkOutput("stall_first_data", ifc.m_axis_word.tdata, 32'h70);
        idx = 0;
        for (int i = 0; i < 13; i++) begin
            r = (i % 3 == 0);
            prevWord = ifc.m_axis_word;
            applyStimulus(1'b0, r);
            if (r) idx++;
            else begin
                checkOutput("stall_no_pop", 32'(lastRdEn), 32'd0);
                checkOutput("stall_hold", ifc.m_axis_word.tdata, prevWord.tdata);
            end
            if (idx < 5) begin
                checkOutput("stall_tvalid", 32'(ifc.m_axis_tvalid), 32'd1);
                checkOutput("stall_data", ifc.m_axis_word.tdata, 32'h70 + 32'(idx));
                checkOutput("stall_last", 32'(ifc.m_axis_word.tlast), 32'(idx == 4));
            end else begin
                checkOutput("stall_end_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
            end
        end
        checkOutput("stall_end_pend", 32'(pendingCnt), 32'd0);
        checkOutput("no_underrun_yet", 32'(errUnderrun), 32'd0);

        // FIFO runs dry inside a packet, then the tail arrives late.
        pushWord(32'h50, 1'b0);
        pushWord(32'h51, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("urun_data51", ifc.m_axis_word.tdata, 32'h51);
        applyStimulus(1'b0, 1'b1);
        checkOutput("urun_flag", 32'(errUnderrun), 32'd1);
        checkOutput("urun_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        pushWord(32'h52, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("urun_resume", {ifc.m_axis_word.tdata[30:0], ifc.m_axis_word.tlast}, {31'h52, 1'b1});
        applyStimulus(1'b0, 1'b1);
        checkOutput("urun_end_pend", 32'(pendingCnt), 32'd0);
        checkOutput("urun_sticky", 32'(errUnderrun), 32'd1);
`ifdef AXIS_EGRESS_STATS_EN
        checkOutput("stat_beats", statBeats, 32'd19);
        checkOutput("stat_pkts", statPkts, 32'd7);
`endif

        // Nine commits into an 8-deep pending counter while the sink is stalled.
        for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b0);
        checkOutput("ovf_pend8", 32'(pendingCnt), 32'd8);
        checkOutput("ovf_not_yet", 32'(errOverflow), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovf_sat", 32'(pendingCnt), 32'd8);
        checkOutput("ovf_flag", 32'(errOverflow), 32'd1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovf_sticky", 32'(errOverflow), 32'd1);

        // Asynchronous reset while beat 2 of 4 is presented.
        doReset();
        for (int b = 0; b < 4; b++) pushWord(32'h80 + 32'(b), b == 3);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid_beat2", ifc.m_axis_word.tdata, 32'h81);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        checkOutput("mid_rst_pend", 32'(pendingCnt), 32'd0);
        checkOutput("mid_rst_rden", 32'(ifc.fifo_rd_en), 32'd0);
`ifdef AXIS_EGRESS_STATS_EN
        checkOutput("mid_rst_stats", statBeats | statPkts, 32'd0);
`endif
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("post_rst_idle_rden", 32'(lastRdEn), 32'd0);
            checkOutput("post_rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
